immgen_stage: RTL and testbench

Parametrised, pipelined immediate-generation stage between instruction fetch and the decode/execute register. Accepts one instruction per cycle with its immediate format select and PC, extracts and extends the immediate to `XLEN`, and computes the PC-relative target. A two-entry skid buffer with valid/ready handshakes on both sides sustains full throughput under backpressure. Adds U-type, CSR zimm and shift-amount formats, selectable XLEN and flush handling over the single-cycle extender.

---
 rtl/common_pkg.sv | 20 ++
 rtl/imm_extract.sv | 36 +++
 rtl/immgen_stage.sv | 124 ++++++++++++
 tb/tb_immgen_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared decode-side types: immediate format selects and the skid-buffer occupancy states.
package common;

  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_U  = 3'd3,
    IMM_J  = 3'd4,
    IMM_Z  = 3'd5,
    IMM_SH = 3'd6
  } imm_sel_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor: builds a 64-bit immediate and keeps the low XLEN bits.
module imm_extract
  import common::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm
);

  logic        s;
  logic [63:0] imm64;
  logic        unused_opcode;

  assign s             = instr[31];
  assign unused_opcode = &{1'b0, instr[6:0]};

  // Sign fill is always taken from instr[31]; truncation to XLEN keeps 32-bit U correct.
  always_comb begin
    imm64 = 64'd0;
    case (imm_sel_t'(sel))
      IMM_I:  imm64 = {{52{s}}, instr[31:20]};
      IMM_S:  imm64 = {{52{s}}, instr[31:25], instr[11:7]};
      IMM_B:  imm64 = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:  imm64 = {{32{s}}, instr[31:12], 12'd0};
      IMM_J:  imm64 = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:  imm64 = {59'd0, instr[19:15]};
      IMM_SH: imm64 = (XLEN == 64) ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
      default: imm64 = 64'd0;
    endcase
  end

  assign imm = imm64[XLEN-1:0];

endmodule

// File: rtl/immgen_stage.sv
// Immediate-generation stage: extract + PC-relative add on the input side, then a
// two-entry skid buffer holding {instr, imm, target} with an EMPTY/ONE/TWO occupancy FSM.
module immgen_stage
  import common::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_sel,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("immgen_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] new_imm;
  logic [XLEN-1:0] new_target;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (in_instr),
    .sel   (in_sel),
    .imm   (new_imm)
  );

  assign new_target = in_pc + new_imm;

  // Handshake: a beat transfers on a rising edge when valid and ready are both high;
  // valid never waits on ready, and both ready/valid here decode only the state register.
  occ_state_t state, next_state;
  logic       accept, pop;
  logic       load_head, load_tail, shift;

  logic [31:0]     head_instr, tail_instr;
  logic [XLEN-1:0] head_imm, tail_imm;
  logic [XLEN-1:0] head_target, tail_target;

  assign in_ready  = (state != OCC_TWO);
  assign out_valid = (state != OCC_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    next_state = state;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift      = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (accept) begin
          next_state = OCC_ONE;
          load_head  = 1'b1;
        end
      end
      OCC_ONE: begin
        if (accept && pop) begin
          load_head = 1'b1;
        end else if (accept) begin
          next_state = OCC_TWO;
          load_tail  = 1'b1;
        end else if (pop) begin
          next_state = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          next_state = OCC_ONE;
          shift      = 1'b1;
        end
      end
      default: next_state = OCC_EMPTY;
    endcase
    // Flush wins over everything, including an accept the upstream believes completed.
    if (flush) begin
      next_state = OCC_EMPTY;
      load_head  = 1'b0;
      load_tail  = 1'b0;
      shift      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= OCC_EMPTY;
      head_instr  <= '0;
      head_imm    <= '0;
      head_target <= '0;
      tail_instr  <= '0;
      tail_imm    <= '0;
      tail_target <= '0;
    end else begin
      state <= next_state;
      if (load_head) begin
        head_instr  <= in_instr;
        head_imm    <= new_imm;
        head_target <= new_target;
      end else if (shift) begin
        head_instr  <= tail_instr;
        head_imm    <= tail_imm;
        head_target <= tail_target;
      end
      if (load_tail) begin
        tail_instr  <= in_instr;
        tail_imm    <= new_imm;
        tail_target <= new_target;
      end
    end
  end

  assign out_instr  = head_instr;
  assign out_imm    = head_imm;
  assign out_target = head_target;

endmodule

// File: tb/tb_immgen_stage.sv
// Directed bench for immgen_stage: format vectors, backpressure ordering, flush and async reset.
module tb_immgen_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic [2:0]  in_sel;
  logic [63:0] in_pc, out_imm, out_target;

  logic        v32_in_valid, v32_in_ready, v32_out_valid;
  logic [31:0] v32_in_instr, v32_out_instr;
  logic [2:0]  v32_in_sel;
  logic [31:0] v32_in_pc, v32_out_imm, v32_out_target;

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  immgen_stage #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_sel(in_sel), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm(out_imm), .out_target(out_target)
  );

  immgen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v32_in_valid), .in_ready(v32_in_ready),
    .in_instr(v32_in_instr), .in_sel(v32_in_sel), .in_pc(v32_in_pc), .flush(1'b0),
    .out_valid(v32_out_valid), .out_ready(1'b1), .out_instr(v32_out_instr),
    .out_imm(v32_out_imm), .out_target(v32_out_target)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pops are checked before same-cycle pushes so a replace-head cycle orders correctly.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check_eq("unexpected_pop", {32'd0, out_instr}, 64'hDEAD);
        else check_eq("order", {32'd0, out_instr}, {32'd0, exp_q.pop_front()});
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_instr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] instr, input logic [2:0] sel,
                         input logic [63:0] pc, input logic [63:0] exp_imm,
                         input logic [63:0] exp_tgt);
    in_valid = 1'b1;
    in_instr = instr;
    in_sel   = sel;
    in_pc    = pc;
    check_eq({tag, "_pre_valid"}, {63'd0, out_valid}, 64'd0);
    step();
    in_valid = 1'b0;
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_instr"}, {32'd0, out_instr}, {32'd0, instr});
    check_eq({tag, "_imm"}, out_imm, exp_imm);
    check_eq({tag, "_target"}, out_target, exp_tgt);
    step();
    check_eq({tag, "_drained"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run_vec32(input string tag, input logic [31:0] instr, input logic [2:0] sel,
                           input logic [31:0] pc, input logic [31:0] exp_imm,
                           input logic [31:0] exp_tgt);
    v32_in_valid = 1'b1;
    v32_in_instr = instr;
    v32_in_sel   = sel;
    v32_in_pc    = pc;
    step();
    v32_in_valid = 1'b0;
    check_eq({tag, "_valid"}, {63'd0, v32_out_valid}, 64'd1);
    check_eq({tag, "_imm"}, {32'd0, v32_out_imm}, {32'd0, exp_imm});
    check_eq({tag, "_target"}, {32'd0, v32_out_target}, {32'd0, exp_tgt});
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_sel = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    v32_in_valid = 1'b0; v32_in_instr = '0; v32_in_sel = '0; v32_in_pc = '0;
    step();
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_instr", {32'd0, out_instr}, 64'd0);
    check_eq("rst_out_imm", out_imm, 64'd0);
    check_eq("rst_out_target", out_target, 64'd0);
    step();
    reset = 1'b0;

    run_vec("i",   32'hFFF00093, 3'd0, 64'h1000,     64'hFFFF_FFFF_FFFF_FFFF, 64'h0FFF);
    run_vec("s",   32'hFE112E23, 3'd1, 64'h2000,     64'hFFFF_FFFF_FFFF_FFFC, 64'h1FFC);
    run_vec("b",   32'hFE000EE3, 3'd2, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8000_000C);
    run_vec("j",   32'h0010006F, 3'd4, 64'h8000_0000, 64'h800,                64'h8000_0800);
    run_vec("u",   32'h800002B7, 3'd3, 64'h0,         64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000);
    run_vec("z",   32'h800F8073, 3'd5, 64'h100,       64'h1F,                  64'h11F);
    run_vec("sh",  32'h83F00013, 3'd6, 64'h200,       64'h3F,                  64'h23F);
    run_vec("rsv", 32'hFFFFFFFF, 3'd7, 64'h300,       64'h0,                   64'h300);

    run_vec32("u32",  32'h800002B7, 3'd3, 32'h10, 32'h8000_0000, 32'h8000_0010);
    run_vec32("sh32", 32'h03F00013, 3'd6, 32'h20, 32'h1F,        32'h3F);

    // Backpressure: A, B fill the buffer, C waits, then all three drain back-to-back.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 3'd0; in_pc = 64'h0; in_instr = 32'h00A00013;
    step();
    check_eq("bp_one_ready", {63'd0, in_ready}, 64'd1);
    in_instr = 32'h00B00013;
    step();
    check_eq("bp_in_ready_drop", {63'd0, in_ready}, 64'd0);
    in_instr = 32'h00C00013;
    step();
    check_eq("bp_head_hold", {32'd0, out_instr}, 64'h00A00013);
    check_eq("bp_still_full", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    check_eq("bp_head_b", {32'd0, out_instr}, 64'h00B00013);
    check_eq("bp_in_ready_rise", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check_eq("bp_head_c", {32'd0, out_instr}, 64'h00C00013);
    check_eq("bp_c_valid", {63'd0, out_valid}, 64'd1);
    step();
    check_eq("bp_drained", {63'd0, out_valid}, 64'd0);

    // Flush in TWO with D offered, then flush in ONE with an accepted-looking G.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h01100013;
    step();
    in_instr = 32'h01200013;
    step();
    in_instr = 32'h0DD00013; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush2_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush2_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_instr = 32'h01300013;
    step();
    in_instr = 32'h0EE00013; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush1_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("flush_no_d", {63'd0, out_valid}, 64'd0);
    end

    // Asynchronous reset in ONE, away from any clock edge.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0FF00013; in_sel = 3'd0;
    step();
    in_valid = 1'b0;
    check_eq("ar_pre_valid", {63'd0, out_valid}, 64'd1);
    #5;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_eq("ar_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("ar_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("ar_out_instr", {32'd0, out_instr}, 64'd0);
    check_eq("ar_out_imm", out_imm, 64'd0);
    check_eq("ar_out_target", out_target, 64'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    run_vec("post_rst", 32'h12300093, 3'd0, 64'h40, 64'h123, 64'h163);

    step();
    check_eq("pop_count", pop_cnt, 64'd12);
    check_eq("queue_empty", exp_q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
